// File: rtl/lfsr_bank_if.sv
// rtl/lfsr_bank_if.sv - control and result bundle for the lfsr_bank channel array
// master: drives en, seed_load, seed_ch, seed_in, threshold; samples rnd_out, fire
// slave : the lfsr_bank itself
interface lfsr_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int OUT_W    = 6
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      en;
  logic                      seed_load;
  logic [SEL_W-1:0]          seed_ch;
  logic [WIDTH-1:0]          seed_in;
  logic [OUT_W-1:0]          threshold;
  logic [CHANNELS*OUT_W-1:0] rnd_out;
  logic [CHANNELS-1:0]       fire;

  modport master (
    output en, seed_load, seed_ch, seed_in, threshold,
    input  rnd_out, fire
  );

  modport slave (
    input  en, seed_load, seed_ch, seed_in, threshold,
    output rnd_out, fire
  );
endinterface

// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - bank of independent Fibonacci LFSRs with threshold fire and cooldown
// frame_clk : clock, all state on rising edge
// Reset     : asynchronous active-high, restores default seeds, clears cooldown and fire
// bus       : lfsr_bank_if.slave (en, seed_load, seed_ch, seed_in, threshold -> rnd_out, fire)
module lfsr_bank #(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 8,
  parameter int          OUT_W     = 6,
  parameter logic [15:0] SEED_BASE = 16'h00AB,
  parameter int          COOLDOWN  = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  lfsr_bank_if.slave  bus
);

  // Maximal-length tap sets, bit (t-1) set for each tap t.
  function automatic logic [15:0] tap_mask16(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]      TAP16 = tap_mask16(WIDTH);
  localparam logic [WIDTH-1:0] TAPS  = TAP16[WIDTH-1:0];
  localparam logic [7:0]       CD_RELOAD = 8'(COOLDOWN);

  // Per-channel reset seed; a zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [WIDTH-1:0] default_seed(input int i);
    logic [WIDTH-1:0] v;
    v = WIDTH'(SEED_BASE) + WIDTH'(i * 16'h0035);
    if (v == '0) v = {{(WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  logic [WIDTH-1:0]          s_q  [CHANNELS];
  logic [WIDTH-1:0]          s_d  [CHANNELS];
  logic [7:0]                cd_q [CHANNELS];
  logic [7:0]                cd_d [CHANNELS];
  logic [CHANNELS-1:0]       fire_q;
  logic [CHANNELS-1:0]       fire_d;
  logic [CHANNELS*OUT_W-1:0] rnd_flat;
  int                        ch_sel;
  logic                      ch_valid;

  // Out-of-range channel selects are possible when CHANNELS is not a power of two.
  assign ch_sel   = int'(bus.seed_ch);
  assign ch_valid = bus.seed_load && (ch_sel < CHANNELS);

  always_comb begin
    fire_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s_d[i]  = s_q[i];
      cd_d[i] = cd_q[i];
      if (ch_valid && (ch_sel == i)) begin
        // Load wins over stepping; cooldown is deliberately left untouched.
        s_d[i] = (bus.seed_in == '0) ? default_seed(i) : bus.seed_in;
      end else if (bus.en) begin
        s_d[i] = {s_q[i][WIDTH-2:0], ^(s_q[i] & TAPS)};
        // Fire decision uses the pre-step value that is currently on rnd_out.
        if ((cd_q[i] == 8'd0) && (s_q[i][OUT_W-1:0] < bus.threshold)) begin
          fire_d[i] = 1'b1;
          cd_d[i]   = CD_RELOAD;
        end else if (cd_q[i] != 8'd0) begin
          cd_d[i] = cd_q[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        s_q[i]  <= default_seed(i);
        cd_q[i] <= 8'd0;
      end
      fire_q <= '0;
    end else begin
      s_q    <= s_d;
      cd_q   <= cd_d;
      fire_q <= fire_d;
    end
  end

  always_comb begin
    rnd_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rnd_flat[i*OUT_W +: OUT_W] = s_q[i][OUT_W-1:0];
    end
  end

  assign bus.rnd_out = rnd_flat;
  assign bus.fire    = fire_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// tb/tb_lfsr_bank.sv - randomized self-checking bench for lfsr_bank against a reference model
module tb_lfsr_bank;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int OW = 6;
  localparam int CD = 3;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_clk = ~frame_clk;

  lfsr_bank_if #(.CHANNELS(CH), .WIDTH(W), .OUT_W(OW)) bus ();
  lfsr_bank #(.CHANNELS(CH), .WIDTH(W), .OUT_W(OW), .SEED_BASE(16'h00AB), .COOLDOWN(CD))
    dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));

  // Three-channel variant: leaves an unused seed_ch code and has no cooldown.
  lfsr_bank_if #(.CHANNELS(3), .WIDTH(W), .OUT_W(OW)) bus3 ();
  lfsr_bank #(.CHANNELS(3), .WIDTH(W), .OUT_W(OW), .SEED_BASE(16'h00AB), .COOLDOWN(0))
    dut3 (.frame_clk(frame_clk), .Reset(Reset), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ms  [CH];
  int         mcd [CH];
  bit         mf  [CH];

  function automatic logic [7:0] dseed(input int i);
    int v;
    v = (16'h00AB + i * 16'h0035) % 256;
    if (v == 0) v = 1;
    return 8'(v);
  endfunction

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    int taps [4] = '{8, 6, 5, 4};
    bit fb = 1'b0;
    foreach (taps[k]) fb ^= s[taps[k]-1];
    return {s[6:0], fb};
  endfunction

  function automatic logic [CH*OW-1:0] exp_rnd();
    logic [CH*OW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*OW +: OW] = ms[i][OW-1:0];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_fire();
    logic [CH-1:0] f;
    for (int i = 0; i < CH; i++) f[i] = mf[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      ms[i] = dseed(i); mcd[i] = 0; mf[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.seed_load = 1'b0;
    bus3.en = 1'b0; bus3.seed_load = 1'b0;
    Reset = 1'b1;
    #7;
    Reset = 1'b0;
    model_reset();
    @(posedge frame_clk); #1;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model by the stated rules.
  task automatic cycle(input bit en, input bit ld, input int ch, input logic [7:0] sin,
                       input logic [5:0] thr);
    logic [7:0] ns [CH];
    int         ncd [CH];
    bit         nf  [CH];
    bus.en = en; bus.seed_load = ld; bus.seed_ch = 2'(ch);
    bus.seed_in = sin; bus.threshold = thr;
    for (int i = 0; i < CH; i++) begin
      ns[i] = ms[i]; ncd[i] = mcd[i]; nf[i] = 1'b0;
      if (ld && ch < CH && ch == i) begin
        ns[i] = (sin == 0) ? dseed(i) : sin;
      end else if (en) begin
        ns[i] = ref_step(ms[i]);
        if (mcd[i] == 0 && ms[i][5:0] < thr) begin
          nf[i] = 1'b1; ncd[i] = CD;
        end else if (mcd[i] > 0) begin
          ncd[i] = mcd[i] - 1;
        end
      end
    end
    @(posedge frame_clk); #1;
    for (int i = 0; i < CH; i++) begin
      ms[i] = ns[i]; mcd[i] = ncd[i]; mf[i] = nf[i];
    end
  endtask

  task automatic test_reset();
    logic [CH*OW-1:0] want;
    do_reset();
    want = {6'h0A, 6'h15, 6'h20, 6'h2B};
    n_checks++;
    if (bus.rnd_out !== want) begin
      n_fail++; $display("FAIL reset_rnd actual=%h required=%h", bus.rnd_out, want);
    end
    n_checks++;
    if (bus.fire !== 4'b0) begin
      n_fail++; $display("FAIL reset_fire actual=%b required=0000", bus.fire);
    end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.s_q[i] !== dseed(i)) begin
        n_fail++; $display("FAIL reset_state ch%0d actual=%h required=%h", i, dut.s_q[i], dseed(i));
      end
    end
  endtask

  task automatic test_period();
    bit         seen [256];
    logic [7:0] cur;
    bit         bad = 1'b0;
    do_reset();
    foreach (seen[k]) seen[k] = 1'b0;
    seen[8'hAB] = 1'b1;
    cycle(1, 0, 0, 8'h00, 6'($urandom));
    n_checks++;
    if (dut.s_q[0] !== 8'h57) begin
      n_fail++; $display("FAIL first_step actual=%h required=57", dut.s_q[0]);
    end
    seen[8'h57] = 1'b1;
    for (int k = 2; k <= 255; k++) begin
      cycle(1, 0, 0, 8'h00, 6'($urandom));
      cur = dut.s_q[0];
      if (k < 255 && (cur == 8'h00 || seen[cur])) bad = 1'b1;
      seen[cur] = 1'b1;
      n_checks++;
      if (bus.rnd_out !== exp_rnd() || bus.fire !== exp_fire()) begin
        n_fail++; $display("FAIL period_step%0d actual=%h/%b required=%h/%b", k, bus.rnd_out, bus.fire, exp_rnd(), exp_fire());
      end
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL period_unique actual=repeat_or_zero required=unique_nonzero");
    end
    n_checks++;
    if (dut.s_q[0] !== 8'hAB) begin
      n_fail++; $display("FAIL period_wrap actual=%h required=ab", dut.s_q[0]);
    end
  endtask

  task automatic test_seed_load();
    cycle(1, 1, 1, 8'h01, 6'h00);
    n_checks++;
    if (bus.rnd_out[OW +: OW] !== 6'h01 || bus.rnd_out !== exp_rnd()) begin
      n_fail++; $display("FAIL load_ch1 actual=%h required=%h", bus.rnd_out, exp_rnd());
    end
    cycle(1, 0, 0, 8'h00, 6'h00);
    n_checks++;
    if (bus.rnd_out[OW +: OW] !== 6'h02) begin
      n_fail++; $display("FAIL load_ch1_step actual=%h required=02", bus.rnd_out[OW +: OW]);
    end
    cycle(1, 1, 2, 8'h00, 6'h00);
    n_checks++;
    if (bus.rnd_out[2*OW +: OW] !== 6'h15 || bus.rnd_out !== exp_rnd()) begin
      n_fail++; $display("FAIL load_zero_seed actual=%h required=%h", bus.rnd_out, exp_rnd());
    end
  endtask

  task automatic test_fire_spacing();
    int last [CH];
    int hits [CH];
    foreach (last[i]) begin last[i] = -100; hits[i] = 0; end
    for (int k = 0; k < 200; k++) begin
      cycle(1, 0, 0, 8'h00, 6'h3F);
      n_checks++;
      if (bus.fire !== exp_fire() || bus.rnd_out !== exp_rnd()) begin
        n_fail++; $display("FAIL fire_model cyc%0d actual=%b required=%b", k, bus.fire, exp_fire());
      end
      for (int i = 0; i < CH; i++) begin
        if (bus.fire[i]) begin
          n_checks++;
          if (k - last[i] < CD + 1) begin
            n_fail++; $display("FAIL fire_gap ch%0d actual=%0d required>=%0d", i, k - last[i], CD + 1);
          end
          last[i] = k; hits[i]++;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (hits[i] == 0) begin
        n_fail++; $display("FAIL fire_seen ch%0d actual=0 required>0", i);
      end
    end
  endtask

  task automatic test_thr_zero();
    for (int k = 0; k < 1000; k++) begin
      cycle(1, 0, 0, 8'h00, 6'h00);
      n_checks++;
      if (bus.fire !== 4'b0000) begin
        n_fail++; $display("FAIL thr_zero cyc%0d actual=%b required=0000", k, bus.fire);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle(1, 0, 0, 8'h00, 6'h3F);
      for (int i = 0; i < CH; i++) if (mcd[i] != 0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL async_precond actual=cd_zero required=cd_nonzero");
    end
    #2 Reset = 1'b1;
    #2;
    n_checks++;
    if (bus.fire !== 4'b0000) begin
      n_fail++; $display("FAIL async_fire actual=%b required=0000", bus.fire);
    end
    for (int i = 0; i < CH; i++) begin
      n_checks++;
      if (dut.s_q[i] !== dseed(i) || dut.cd_q[i] !== 8'd0) begin
        n_fail++; $display("FAIL async_state ch%0d actual=%h/%0d required=%h/0", i, dut.s_q[i], dut.cd_q[i], dseed(i));
      end
    end
    #2 Reset = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 0, 8'h00, 6'h3F);
      n_checks++;
      if (bus.fire !== exp_fire() || bus.rnd_out !== exp_rnd()) begin
        n_fail++; $display("FAIL async_resume cyc%0d actual=%h/%b required=%h/%b", k, bus.rnd_out, bus.fire, exp_rnd(), exp_fire());
      end
    end
  endtask

  task automatic test_en_low();
    logic [CH*OW-1:0] snap;
    for (int k = 0; k < 20; k++) cycle(1, 0, 0, 8'h00, 6'($urandom));
    snap = bus.rnd_out;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 8'($urandom), 6'($urandom));
      n_checks++;
      if (bus.rnd_out !== snap || bus.fire !== 4'b0000) begin
        n_fail++; $display("FAIL en_low cyc%0d actual=%h/%b required=%h/0000", k, bus.rnd_out, bus.fire, snap);
      end
    end
    for (int k = 0; k < 30; k++) begin
      cycle(1, 0, 0, 8'h00, 6'($urandom));
      n_checks++;
      if (bus.rnd_out !== exp_rnd() || bus.fire !== exp_fire()) begin
        n_fail++; $display("FAIL en_resume cyc%0d actual=%h/%b required=%h/%b", k, bus.rnd_out, bus.fire, exp_rnd(), exp_fire());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, CH-1)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            6'($urandom));
      n_checks++;
      if (bus.rnd_out !== exp_rnd() || bus.fire !== exp_fire()) begin
        n_fail++; $display("FAIL random cyc%0d actual=%h/%b required=%h/%b", k, bus.rnd_out, bus.fire, exp_rnd(), exp_fire());
      end
    end
  endtask

  task automatic test_bad_channel();
    logic [7:0] st [3];
    logic [2:0] wf;
    do_reset();
    for (int i = 0; i < 3; i++) st[i] = dseed(i);
    for (int k = 0; k < 3; k++) begin
      bus3.en = 1'b1; bus3.seed_load = (k == 0); bus3.seed_ch = 2'd3;
      bus3.seed_in = 8'h5A; bus3.threshold = 6'h3F;
      // No cooldown: every enabled edge fires whenever the low bits are below 0x3F.
      for (int i = 0; i < 3; i++) begin
        wf[i] = (st[i][5:0] < 6'h3F);
        st[i] = ref_step(st[i]);
      end
      @(posedge frame_clk); #1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (bus3.rnd_out[i*OW +: OW] !== st[i][5:0] || bus3.fire[i] !== wf[i]) begin
          n_fail++; $display("FAIL bad_ch cyc%0d ch%0d actual=%h/%b required=%h/%b", k, i, bus3.rnd_out[i*OW +: OW], bus3.fire[i], st[i][5:0], wf[i]);
        end
      end
    end
    bus3.en = 1'b0; bus3.seed_load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.seed_load = 1'b0; bus.seed_ch = '0; bus.seed_in = '0; bus.threshold = '0;
    bus3.en = 1'b0; bus3.seed_load = 1'b0; bus3.seed_ch = '0; bus3.seed_in = '0; bus3.threshold = '0;
    model_reset();
    test_reset();
    test_period();
    test_seed_load();
    test_fire_spacing();
    test_thr_zero();
    test_async_reset();
    test_en_low();
    test_random();
    test_bad_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
